iter_shifter: RTL

- Parametrised multi-cycle shifter; successor to the fixed 3-bit arithmetic-right and logical-left shift blocks.
- Runtime shift amount and four modes: LSL, LSR, ASR and ROR.
- Shifts STEP bits per clock under a start/busy/done handshake.
- Sits in the datapath wherever an area-cheap variable shift replaces a full barrel shifter.

---
 rtl/iter_shifter.sv | 112 +++++++++++
 1 files changed

// File: rtl/iter_shifter.sv
// rtl/iter_shifter.sv - multi-cycle LSL/LSR/ASR/ROR shifter, up to STEP bits per clock
module iter_shifter #(
    parameter int  WIDTH = 32,
    parameter int  STEP  = 1,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    input  logic [SHW-1:0]   amt,
    input  logic [1:0]       mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] f
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] M_LSL = 2'b00;
    localparam logic [1:0] M_LSR = 2'b01;
    localparam logic [1:0] M_ASR = 2'b10;
    localparam logic [1:0] M_ROR = 2'b11;

    localparam logic [SHW-1:0] STEP_C  = SHW'(STEP);
    localparam logic [SHW:0]   WIDTH_C = (SHW + 1)'(WIDTH);

    state_t           state, state_n;
    logic [WIDTH-1:0] data;
    logic [SHW-1:0]   cnt;
    logic [1:0]       op;

    logic             accept;
    logic [SHW-1:0]   k;
    logic [SHW-1:0]   cnt_nxt;
    logic [SHW:0]     rot_amt;
    logic [WIDTH-1:0] shifted;

    assign busy   = (state == SHIFT);
    assign done   = (state == DONE);
    assign accept = start && (state != SHIFT);

    // The final step may be partial: never shift past the remaining count.
    always_comb begin
        k       = (cnt < STEP_C) ? cnt : STEP_C;
        cnt_nxt = cnt - k;
        rot_amt = WIDTH_C - {1'b0, k};
        shifted = data;
        case (op)
            M_LSL:   shifted = data << k;
            M_LSR:   shifted = data >> k;
            M_ASR:   shifted = $unsigned($signed(data) >>> k);
            M_ROR:   shifted = (data >> k) | (data << rot_amt);
            default: shifted = data;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    state_n = (amt == '0) ? DONE : SHIFT;
                end else begin
                    state_n = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_nxt == '0) begin
                    state_n = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // f is written only on the edge that enters DONE, so it holds across later operations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
            cnt  <= '0;
            op   <= '0;
            f    <= '0;
        end else if (accept) begin
            data <= in;
            cnt  <= amt;
            op   <= mode;
            if (amt == '0) begin
                f <= in;
            end
        end else if (state == SHIFT) begin
            data <= shifted;
            cnt  <= cnt_nxt;
            if (cnt_nxt == '0) begin
                f <= shifted;
            end
        end
    end

endmodule
